// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        OWNER_IMEM = 1'b0,
        OWNER_DMEM = 1'b1
    } owner_e;

    localparam int OUTSTANDING_DEFAULT = 2;

    // Index width for a power-of-two depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_owner_fifo.sv
// In-order FIFO of 1-bit owner IDs: remembers who issued each accepted request
// so responses can be routed back in issue order.
module mem_arb_owner_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = OUTSTANDING_DEFAULT
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   push,
    input  owner_e push_owner,
    input  logic   pop,
    output logic   full,
    output logic   empty,
    output owner_e head
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] slot_q, slot_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = owner_e'(slot_q[rd_ptr_q]);
    // A full FIFO refuses a push even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign slot_d[gi] = (do_push && (wr_ptr_q == PTR_W'(gi))) ? push_owner : slot_q[gi];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between IMEM and DMEM requesters.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; default is DMEM-priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int OUTSTANDING = OUTSTANDING_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_req,
    output logic        imem_gnt,
    input  logic        imem_wen,
    input  logic [3:0]  imem_strb,
    input  logic [31:0] imem_addr,
    input  logic [31:0] imem_wdata,
    output logic        imem_recv,
    input  logic        imem_ack,
    output logic [31:0] imem_rdata,
    output logic        imem_error,
    input  logic        dmem_req,
    output logic        dmem_gnt,
    input  logic        dmem_wen,
    input  logic [3:0]  dmem_strb,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_recv,
    input  logic        dmem_ack,
    output logic [31:0] dmem_rdata,
    output logic        dmem_error,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_wen,
    output logic [3:0]  mem_strb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_recv,
    output logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error
);

    logic   lock_q, lock_d;
    owner_e lock_owner_q, lock_owner_d;
    owner_e sel;
    logic   sel_req;
    logic   accept;
    logic   fifo_full;
    logic   fifo_empty;
    owner_e fifo_head;
    logic   resp_imem;
    logic   resp_dmem;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = sel;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= OWNER_DMEM;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        sel = OWNER_IMEM;
        if (lock_q) begin
            sel = lock_owner_q;
        end else if (imem_req && !dmem_req) begin
            sel = OWNER_IMEM;
        end else if (dmem_req && !imem_req) begin
            sel = OWNER_DMEM;
        end else if (imem_req && dmem_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            sel = (last_q == OWNER_IMEM) ? OWNER_DMEM : OWNER_IMEM;
`else
            sel = OWNER_DMEM;
`endif
        end
    end

    assign sel_req = (sel == OWNER_IMEM) ? imem_req : dmem_req;
    assign mem_req = sel_req && !fifo_full;
    assign accept  = mem_req && mem_gnt;
    assign imem_gnt = accept && (sel == OWNER_IMEM);
    assign dmem_gnt = accept && (sel == OWNER_DMEM);

    always_comb begin
        mem_wen   = 1'b0;
        mem_strb  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (imem_req || dmem_req) begin
            if (sel == OWNER_IMEM) begin
                mem_wen   = imem_wen;
                mem_strb  = imem_strb;
                mem_addr  = imem_addr;
                mem_wdata = imem_wdata;
            end else begin
                mem_wen   = dmem_wen;
                mem_strb  = dmem_strb;
                mem_addr  = dmem_addr;
                mem_wdata = dmem_wdata;
            end
        end
    end

    // Hold the stalled owner so its address/data stay on the bus until accepted.
    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        if (mem_req && !mem_gnt) begin
            lock_d       = 1'b1;
            lock_owner_d = sel;
        end else if (mem_gnt) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_IMEM;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
        end
    end

    mem_arb_owner_fifo #(
        .DEPTH(OUTSTANDING)
    ) u_owner_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (accept),
        .push_owner(sel),
        .pop       (mem_recv && mem_ack),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // With no owner on record a response is spurious: swallow it.
    assign resp_imem  = !fifo_empty && (fifo_head == OWNER_IMEM);
    assign resp_dmem  = !fifo_empty && (fifo_head == OWNER_DMEM);
    assign mem_ack    = fifo_empty ? mem_recv : (resp_imem ? imem_ack : dmem_ack);
    assign imem_recv  = resp_imem && mem_recv;
    assign dmem_recv  = resp_dmem && mem_recv;
    assign imem_rdata = resp_imem ? mem_rdata : '0;
    assign dmem_rdata = resp_dmem ? mem_rdata : '0;
    assign imem_error = resp_imem && mem_error;
    assign dmem_error = resp_dmem && mem_error;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random bench for mem_port_arbiter against a queue-based reference model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int OUT = 2;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req, imem_gnt, imem_wen, imem_recv, imem_ack, imem_error;
    logic [3:0]  imem_strb;
    logic [31:0] imem_addr, imem_wdata, imem_rdata;
    logic        dmem_req, dmem_gnt, dmem_wen, dmem_recv, dmem_ack, dmem_error;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_req, mem_gnt, mem_wen, mem_recv, mem_ack, mem_error;
    logic [3:0]  mem_strb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clock = ~clock;

    mem_port_arbiter #(.OUTSTANDING(OUT)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_wen(imem_wen), .imem_strb(imem_strb),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_recv(imem_recv), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_error(imem_error),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_recv(dmem_recv), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .dmem_error(dmem_error),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_strb(mem_strb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_recv(mem_recv), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_error(mem_error)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owners of accepted requests in issue order, stalled owner, last winner.
    int q[$];
    bit lock_v;
    int lock_o;
    int last_g;
    int m_sel, m_head;
    bit m_mreq, m_ack, m_ig, m_dg;
    bit i_pend, d_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        imem_req = 0; imem_wen = 0; imem_strb = 0; imem_addr = 0; imem_wdata = 0; imem_ack = 0;
        dmem_req = 0; dmem_wen = 0; dmem_strb = 0; dmem_addr = 0; dmem_wdata = 0; dmem_ack = 0;
        mem_gnt = 0; mem_recv = 0; mem_rdata = 0; mem_error = 0;
    endtask

    // Settle combinational outputs, then compare against the model's view of this cycle.
    task automatic eval();
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_strb;
        logic        e_wen, sel_req;
        #1;
        m_sel = -1;
        if (lock_v) m_sel = lock_o;
        else if (imem_req && dmem_req) m_sel = RR ? ((last_g == 0) ? 1 : 0) : 1;
        else if (imem_req) m_sel = 0;
        else if (dmem_req) m_sel = 1;
        sel_req = (m_sel == 0) ? imem_req : (m_sel == 1) ? dmem_req : 1'b0;
        m_mreq = sel_req && (q.size() < OUT);
        m_ig = m_mreq && mem_gnt && (m_sel == 0);
        m_dg = m_mreq && mem_gnt && (m_sel == 1);
        e_addr = 0; e_wdata = 0; e_strb = 0; e_wen = 0;
        if ((imem_req || dmem_req) && m_sel == 0) begin
            e_addr = imem_addr; e_wdata = imem_wdata; e_strb = imem_strb; e_wen = imem_wen;
        end else if ((imem_req || dmem_req) && m_sel == 1) begin
            e_addr = dmem_addr; e_wdata = dmem_wdata; e_strb = dmem_strb; e_wen = dmem_wen;
        end
        chk("mem_req", mem_req, m_mreq);
        chk("imem_gnt", imem_gnt, m_ig);
        chk("dmem_gnt", dmem_gnt, m_dg);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("mem_strb", mem_strb, e_strb);
        chk("mem_wen", mem_wen, e_wen);
        m_head = (q.size() > 0) ? q[0] : -1;
        m_ack = (m_head < 0) ? mem_recv : ((m_head == 0) ? imem_ack : dmem_ack);
        chk("mem_ack", mem_ack, m_ack);
        chk("imem_recv", imem_recv, (m_head == 0) && mem_recv);
        chk("dmem_recv", dmem_recv, (m_head == 1) && mem_recv);
        if (m_head != 0) begin
            chk("imem_rdata_zero", imem_rdata, 0);
            chk("imem_error_zero", imem_error, 0);
        end else if (mem_recv) begin
            chk("imem_rdata", imem_rdata, mem_rdata);
            chk("imem_error", imem_error, mem_error);
        end
        if (m_head != 1) begin
            chk("dmem_rdata_zero", dmem_rdata, 0);
            chk("dmem_error_zero", dmem_error, 0);
        end else if (mem_recv) begin
            chk("dmem_rdata", dmem_rdata, mem_rdata);
            chk("dmem_error", dmem_error, mem_error);
        end
    endtask

    // Apply this cycle's handshakes to the model, then move to the next cycle.
    task automatic tick();
        if (m_head >= 0 && mem_recv && m_ack) void'(q.pop_front());
        if (m_mreq && mem_gnt) begin
            q.push_back(m_sel);
            last_g = m_sel;
        end
        if (m_mreq && !mem_gnt) begin
            lock_v = 1;
            lock_o = m_sel;
        end else if (mem_gnt) begin
            lock_v = 0;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        idle_inputs();
        i_pend = 0; d_pend = 0;
        reset = 1;
        mem_rdata = 32'hFFFF_FFFF;
        mem_error = 1;
        @(negedge clock);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_ack", mem_ack, 0);
        chk("rst_gnts", {imem_gnt, dmem_gnt}, 0);
        chk("rst_recvs", {imem_recv, dmem_recv}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_imem_rdata", imem_rdata, 0);
        chk("rst_dmem_rdata", dmem_rdata, 0);
        chk("rst_errors", {imem_error, dmem_error}, 0);
        q.delete();
        lock_v = 0; lock_o = 0; last_g = 1;
        reset = 0;
        mem_rdata = 0;
        mem_error = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        repeat (2) @(negedge clock);

        // Single IMEM read with response.
        do_reset();
        imem_req = 1; imem_addr = 32'h100; imem_strb = 4'hF; mem_gnt = 1;
        eval();
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_imem_gnt", imem_gnt, 1);
        tick();
        imem_req = 0; mem_gnt = 0; mem_recv = 1; mem_rdata = 32'hDEADBEEF; imem_ack = 1;
        eval();
        chk("t1_imem_recv", imem_recv, 1);
        chk("t1_imem_rdata", imem_rdata, 32'hDEADBEEF);
        chk("t1_dmem_recv", dmem_recv, 0);
        tick();

        // Continuous contention.
        do_reset();
        imem_req = 1; imem_addr = 32'h1000; dmem_req = 1; dmem_addr = 32'h2000;
        mem_gnt = 1; mem_recv = 1; imem_ack = 1; dmem_ack = 1;
        for (int k = 0; k < 4; k++) begin
            eval();
            chk("t2_imem_gnt", imem_gnt, RR ? ((k % 2) == 0) : 1'b0);
            chk("t2_dmem_gnt", dmem_gnt, RR ? ((k % 2) == 1) : 1'b1);
            tick();
        end

        // Stall holds the locked IMEM request while DMEM arrives.
        do_reset();
        imem_req = 1; imem_addr = 32'h40; imem_wdata = 32'hA5A5_0001;
        dmem_addr = 32'h80; dmem_wdata = 32'h5A5A_0002;
        for (int k = 0; k < 3; k++) begin
            dmem_req = (k >= 1);
            eval();
            chk("t3_hold_addr", mem_addr, 32'h40);
            tick();
        end
        mem_gnt = 1;
        eval();
        chk("t3_imem_gnt", imem_gnt, 1);
        chk("t3_dmem_gnt", dmem_gnt, 0);
        chk("t3_addr", mem_addr, 32'h40);
        tick();

        // Owner FIFO full, then in-order routing.
        do_reset();
        imem_req = 1; imem_addr = 32'h200; mem_gnt = 1;
        eval(); tick();
        imem_req = 0; dmem_req = 1; dmem_addr = 32'h300;
        eval(); tick();
        dmem_req = 0; imem_req = 1; imem_addr = 32'h204;
        mem_recv = 1; imem_ack = 1; dmem_ack = 1; mem_rdata = 32'h1111_1111;
        eval();
        chk("t4_full_mem_req", mem_req, 0);
        chk("t4_resp1_imem", imem_recv, 1);
        chk("t4_resp1_dmem", dmem_recv, 0);
        tick();
        mem_gnt = 0; mem_rdata = 32'h2222_2222;
        eval();
        chk("t4_after_pop_req", mem_req, 1);
        chk("t4_resp2_dmem", dmem_recv, 1);
        chk("t4_resp2_imem", imem_recv, 0);
        chk("t4_resp2_rdata", dmem_rdata, 32'h2222_2222);
        tick();

        // Reset with two outstanding, then a spurious response and fresh contention.
        do_reset();
        imem_req = 1; imem_addr = 32'h400; mem_gnt = 1;
        eval(); tick();
        imem_req = 0; dmem_req = 1; dmem_addr = 32'h500;
        eval(); tick();
        do_reset();
        mem_recv = 1; mem_rdata = 32'hBAD0_BAD0; imem_ack = 1; dmem_ack = 1;
        eval();
        chk("t6_spurious_ack", mem_ack, 1);
        chk("t6_spurious_irecv", imem_recv, 0);
        chk("t6_spurious_drecv", dmem_recv, 0);
        tick();
        mem_recv = 0; imem_req = 1; dmem_req = 1; mem_gnt = 1;
        eval();
        chk("t6_first_imem_gnt", imem_gnt, RR);
        chk("t6_first_dmem_gnt", dmem_gnt, !RR);
        tick();

        // Randomized traffic with requests held until granted.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (!i_pend && ($urandom_range(2) == 0)) begin
                i_pend = 1;
                imem_wen = $urandom_range(1); imem_strb = 4'($urandom);
                imem_addr = $urandom; imem_wdata = $urandom;
            end
            if (!d_pend && ($urandom_range(2) == 0)) begin
                d_pend = 1;
                dmem_wen = $urandom_range(1); dmem_strb = 4'($urandom);
                dmem_addr = $urandom; dmem_wdata = $urandom;
            end
            imem_req = i_pend;
            dmem_req = d_pend;
            mem_gnt = ($urandom_range(9) < 6);
            mem_recv = $urandom_range(1);
            mem_rdata = $urandom;
            mem_error = ($urandom_range(7) == 0);
            imem_ack = ($urandom_range(3) != 0);
            dmem_ack = ($urandom_range(3) != 0);
            eval();
            if (m_ig) i_pend = 0;
            if (m_dg) d_pend = 0;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
